// File: rtl/sum_bcd_formatter_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg : definitions shared by the sum_bcd_formatter slice.
//   state_t         - formatter FSM encoding (IDLE / SHIFT / DONE)
//   ADJ3_THRESHOLD  - digit value at which double-dabble adds 3
//   ADJ3_OFFSET     - correction added to such a digit
//   SEG_BLANK       - active-low 7-segment pattern with every segment off
//   seg7_code()     - active-low g..a pattern for a BCD digit (blank if > 9)
//   clog10_digits() - decimal digits needed to show 2^(data_w-1)
// ---------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] ADJ3_THRESHOLD = 4'd5;
    localparam logic [3:0] ADJ3_OFFSET    = 4'd3;
    localparam logic [6:0] SEG_BLANK      = 7'b1111111;

    // Bit 6 = segment g ... bit 0 = segment a; a 0 lights the segment.
    function automatic logic [6:0] seg7_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Smallest n with 10^n > 2^(data_w-1): the largest magnitude a signed
    // data_w-bit value can have is 2^(data_w-1) (the most-negative value).
    function automatic int clog10_digits(input int data_w);
        longint lim;
        longint p;
        int     n;
        lim = longint'(1) << (data_w - 1);
        p   = 1;
        n   = 0;
        while (p <= lim) begin
            p = p * 10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/sum_bcd_formatter_if.sv
// ---------------------------------------------------------------------------
// sum_bcd_formatter_if : request / result bundle of the sum_bcd_formatter.
//   start, value  - request from the adder stage (master -> slave)
//   busy, done    - conversion status (slave -> master)
//   sign, bcd     - formatted result, bcd digit 0 (units) in [3:0]
//   state         - debug view of the formatter FSM
//   seg, seg_minus- active-low 7-segment outputs, present only when
//                   SUM_BCD_SEG_DECODE_EN is defined
//
// Handshake: start is a one-cycle request with no ready; it is accepted
// only when the formatter is idle or in its done cycle, and value is sampled
// on that edge alone. A start while busy is dropped. done is a one-cycle
// pulse and sign/bcd hold from that cycle until the next done.
// ---------------------------------------------------------------------------
interface sum_bcd_formatter_if
    import calc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NDIG   = 3
) ();

    logic                start;
    logic [DATA_W-1:0]   value;
    logic                busy;
    logic                done;
    logic                sign;
    logic [4*NDIG-1:0]   bcd;
    state_t              state;
`ifdef SUM_BCD_SEG_DECODE_EN
    logic [7*NDIG-1:0]   seg;
    logic                seg_minus;

    modport master (output start, value,
                    input  busy, done, sign, bcd, state, seg, seg_minus);
    modport slave  (input  start, value,
                    output busy, done, sign, bcd, state, seg, seg_minus);
`else
    modport master (output start, value,
                    input  busy, done, sign, bcd, state);
    modport slave  (input  start, value,
                    output busy, done, sign, bcd, state);
`endif

endinterface

// File: rtl/sum_bcd_formatter_adj3.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj3 : double-dabble correction for one BCD digit.
//   din  - scratch digit before the shift
//   dout - din + 3 when din >= 5, otherwise din
// Adding 3 before the left shift makes a digit >= 5 carry into the next
// digit after the shift, keeping every digit in 0..9.
// ---------------------------------------------------------------------------
module bcd_digit_adj3
    import calc_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= ADJ3_THRESHOLD) ? (din + ADJ3_OFFSET) : din;

endmodule

// File: rtl/sum_bcd_formatter_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7 : one BCD digit to an active-low g..a segment pattern.
//   bcd - digit 0..9 (other codes show blank)
//   seg - bit 6 = g ... bit 0 = a, 0 lights the segment
// Only built when SUM_BCD_SEG_DECODE_EN is defined.
// ---------------------------------------------------------------------------
`ifdef SUM_BCD_SEG_DECODE_EN
module bcd_to_seg7
    import calc_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg7_code(bcd);

endmodule
`endif

// File: rtl/sum_bcd_formatter.sv
// ---------------------------------------------------------------------------
// sum_bcd_formatter : signed adder result -> sign + BCD magnitude.
//   clk  - system clock, all state on the rising edge
//   rst  - asynchronous, active-low reset
//   bus  - sum_bcd_formatter_if.slave (start/value in; busy/done/sign/bcd
//          and debug state out; seg/seg_minus with SUM_BCD_SEG_DECODE_EN)
//
// An accepted start captures |value| and its sign, then a shift-add-3
// (double-dabble) loop converts one bit per clock for DATA_W clocks. The
// result is loaded into sign/bcd on the edge entering DONE, so those
// outputs only ever change to a complete result.
// Optional macro: SUM_BCD_SEG_DECODE_EN adds registered 7-segment outputs.
// ---------------------------------------------------------------------------
module sum_bcd_formatter
    import calc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NDIG   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    sum_bcd_formatter_if.slave   bus
);

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(DATA_W + 1);

    if (NDIG < clog10_digits(DATA_W)) begin : g_bad_ndig
        $error("sum_bcd_formatter: NDIG too small for DATA_W");
    end

    state_t              state;
    logic [DATA_W-1:0]   mag;
    logic [BCD_W-1:0]    scratch;
    logic [CNT_W-1:0]    cnt;
    logic                sign_int;
    logic                busy_r;
    logic                done_r;
    logic                sign_r;
    logic [BCD_W-1:0]    bcd_r;

    logic [BCD_W-1:0]    adj;
    logic [BCD_W-1:0]    next_bcd;
    logic [DATA_W-1:0]   cap_mag;

    // Two's-complement negate; the most-negative value maps onto itself,
    // which read as unsigned is exactly 2^(DATA_W-1).
    assign cap_mag = bus.value[DATA_W-1]
                   ? (~bus.value + {{(DATA_W-1){1'b0}}, 1'b1})
                   : bus.value;

    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        bcd_digit_adj3 u_adj (
            .din  (scratch[4*i +: 4]),
            .dout (adj[4*i +: 4])
        );
    end

    // Scratch digits after this cycle's add-3 and shift-in of mag's MSB.
    assign next_bcd = {adj[BCD_W-2:0], mag[DATA_W-1]};

`ifdef SUM_BCD_SEG_DECODE_EN
    logic [7*NDIG-1:0]   seg_next;
    logic [7*NDIG-1:0]   seg_r;
    logic                seg_minus_r;

    for (genvar i = 0; i < NDIG; i++) begin : g_seg
        bcd_to_seg7 u_seg (
            .bcd (next_bcd[4*i +: 4]),
            .seg (seg_next[7*i +: 7])
        );
    end

    assign bus.seg       = seg_r;
    assign bus.seg_minus = seg_minus_r;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mag      <= '0;
            scratch  <= '0;
            cnt      <= '0;
            sign_int <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sign_r   <= 1'b0;
            bcd_r    <= '0;
`ifdef SUM_BCD_SEG_DECODE_EN
            seg_r       <= {NDIG{SEG_BLANK}};
            seg_minus_r <= 1'b1;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                SHIFT: begin
                    scratch <= next_bcd;
                    mag     <= {mag[DATA_W-2:0], 1'b0};
                    cnt     <= cnt - 1'b1;
                    // cnt == 1: this cycle performs the final shift, so the
                    // result goes straight to the outputs.
                    if (cnt == CNT_W'(1)) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        sign_r <= sign_int;
                        bcd_r  <= next_bcd;
`ifdef SUM_BCD_SEG_DECODE_EN
                        seg_r       <= seg_next;
                        seg_minus_r <= ~sign_int;
`endif
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (bus.start) begin
                        state    <= SHIFT;
                        busy_r   <= 1'b1;
                        sign_int <= bus.value[DATA_W-1];
                        mag      <= cap_mag;
                        scratch  <= '0;
                        cnt      <= CNT_W'(DATA_W);
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.sign  = sign_r;
    assign bus.bcd   = bcd_r;
    assign bus.state = state;

endmodule
